// File: rtl/tft_pkg.sv
// tft_pkg: shared state encoding, RGB565 field layout and default fill colour for the TFT pixel path.
package tft_pkg;
    typedef enum logic [1:0] {RESYNC, ARMED, ACTIVE} feed_state_t;
    localparam int RGB565_R_LSB = 11;
    localparam int RGB565_R_W   = 5;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_G_W   = 6;
    localparam int RGB565_B_LSB = 0;
    localparam int RGB565_B_W   = 5;
    localparam logic [15:0] UNDERFLOW_RGB565 = 16'hF81F;
endpackage

// File: rtl/tft_pixel_feeder_sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty/count; the head entry is presented combinationally.
module sync_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = wr_ptr == rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/tft_pixel_feeder.sv
// tft_pixel_feeder: buffers framebuffer pixels and emits one registered pixel per active
// pixel-clock edge, keeping frame alignment through the sof marker and flagging underflow.
module tft_pixel_feeder
    import tft_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter logic [DATA_W-1:0] UNDERFLOW_COLOR = DATA_W'(UNDERFLOW_RGB565)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pclk_i,
    input  logic              hs_i,
    input  logic              vs_i,
    input  logic              den_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_sof_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [DATA_W-1:0] rgb_o,
    output logic              underflow_o,
    output logic              frame_done_o
);
    localparam int DOT_W  = $clog2(WIDTH);
    localparam int LINE_W = $clog2(HEIGHT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    feed_state_t       state;
    logic              pclk_q, vs_q, hs_q;
    logic [DOT_W-1:0]  dot;
    logic [LINE_W-1:0] line;
    logic [DATA_W:0]   head;
    logic              full, empty, push, pop;
    logic [CNT_W-1:0]  count, count_next;
    logic              pe, vs_rise, hs_fall, slot, early_sof, misalign, last_dot, last_px;

    assign pe        = pclk_i & ~pclk_q;
    assign vs_rise   = vs_i & ~vs_q;
    assign hs_fall   = ~hs_i & hs_q;
    assign slot      = (state == ACTIVE) & pe & den_i;
    assign early_sof = ~empty & head[DATA_W] & ((dot != '0) | (line != '0));
    // A slot decides alignment on its own; sync-edge checks only apply between slots.
    assign misalign  = (state == ACTIVE) & (slot ? early_sof : (vs_rise | (hs_fall & (dot != '0))));
    assign pop       = ((state == RESYNC) & ~empty & ~head[DATA_W]) | (slot & ~empty & ~early_sof);
    assign push      = s_valid_i & s_ready_o & ~full;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign last_dot  = dot == DOT_W'(WIDTH - 1);
    assign last_px   = last_dot & (line == LINE_W'(HEIGHT - 1));

    sync_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata ({s_sof_i, s_data_i}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= RESYNC;
            pclk_q       <= 1'b0;
            vs_q         <= 1'b1;
            hs_q         <= 1'b1;
            dot          <= '0;
            line         <= '0;
            rgb_o        <= '0;
            underflow_o  <= 1'b0;
            frame_done_o <= 1'b0;
            s_ready_o    <= 1'b0;
        end else begin
            pclk_q       <= pclk_i;
            vs_q         <= vs_i;
            hs_q         <= hs_i;
            frame_done_o <= 1'b0;
            s_ready_o    <= count_next != CNT_W'(FIFO_DEPTH);
            case (state)
                RESYNC: if (~empty & head[DATA_W]) state <= ARMED;
                ARMED: if (vs_rise) begin
                    state       <= ACTIVE;
                    dot         <= '0;
                    line        <= '0;
                    underflow_o <= 1'b0;
                end
                ACTIVE: if (misalign) begin
                    state       <= RESYNC;
                    underflow_o <= 1'b1;
                    dot         <= '0;
                    line        <= '0;
                end else if (slot) begin
                    rgb_o <= empty ? UNDERFLOW_COLOR : head[DATA_W-1:0];
                    if (empty) underflow_o <= 1'b1;
                    if (last_px) begin
                        dot          <= '0;
                        line         <= '0;
                        frame_done_o <= 1'b1;
                        state        <= (underflow_o | empty) ? RESYNC : ARMED;
                    end else if (last_dot) begin
                        dot  <= '0;
                        line <= line + LINE_W'(1);
                    end else begin
                        dot <= dot + DOT_W'(1);
                    end
                end
                default: state <= RESYNC;
            endcase
        end
    end
endmodule
